// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: config FSM states,
// default sizing and the divisor value that disables a channel.
package tick_sched_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 32;
  localparam int DIV_DISABLED = 0;

endpackage

// File: rtl/tick_scheduler_channel.sv
// One programmable tick generator: divisor register, up-counter, registered
// tick and a combinational terminal-count flag used for boundary applies.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             term,
  output logic [CNT_W-1:0] div
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             enabled;

  assign enabled = (div != CNT_W'(DIV_DISABLED));
  // One extra bit so a divisor of all-ones is reached without wrapping.
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign term    = run && enabled && (cnt_inc == {1'b0, div});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      div  <= CNT_W'(DIV_DISABLED);
      tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of cnt/div, so term and the load see the old period.
      tick <= term && !clear;
      if (load) begin
        div <= load_div;
        cnt <= '0;
      end else if (clear && enabled) begin
        cnt <= '0;
      end else if (run && enabled) begin
        cnt <= term ? '0 : cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// NUM_CH tick generators with a valid/ready config port that retimes divisor
// changes onto tick boundaries. Define TICK_SCHED_SYNC_EN to add sync_all.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef TICK_SCHED_SYNC_EN
  input  logic              sync_all,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_pending
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  cfg_state_e       state;
  logic [CH_W-1:0]  pend_ch;
  logic [CNT_W-1:0] pend_div;

  logic              sync;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] load;
  logic [CNT_W-1:0]  ch_div [NUM_CH];
  logic [CNT_W-1:0]  load_div;
  logic              accept, in_range, tgt_idle, pend_term;
  logic              apply_now, apply_pend;

`ifdef TICK_SCHED_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  assign accept   = cfg_valid && cfg_ready && !rst;
  assign in_range = ({1'b0, cfg_ch} < NUM_CH_V);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the loop can leave it unassigned and infer a latch.
    tgt_idle  = 1'b0;
    pend_term = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i) && ch_div[i] == CNT_W'(DIV_DISABLED)) tgt_idle = 1'b1;
      if (pend_ch == CH_W'(i)) pend_term = term[i];
    end
  end

  // Idle or stopped channels take a new divisor at once; running ones wait.
  assign apply_now  = accept && in_range && (tgt_idle || !run);
  assign apply_pend = (state == PENDING) && !rst && (pend_term || !run || sync);
  assign load_div   = apply_pend ? pend_div : cfg_div;

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = (apply_now && cfg_ch == CH_W'(i)) || (apply_pend && pend_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
      pend_ch     <= '0;
      pend_div    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && in_range && !apply_now) begin
            state       <= PENDING;
            cfg_ready   <= 1'b0;
            cfg_pending <= 1'b1;
            pend_ch     <= cfg_ch;
            pend_div    <= cfg_div;
          end
        end
        PENDING: begin
          if (apply_pend) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            cfg_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .clear    (sync),
      .load     (load[g]),
      .load_div (load_div),
      .tick     (tick[g]),
      .term     (term[g]),
      .div      (ch_div[g])
    );
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Owns NUM_CH independent programmable tick generators. Each produces a one-cycle enable pulse every `div` clk cycles.
- Lets the host reprogram any channel's divisor at run time through a valid/ready config port.
- New divisors are applied only on a tick boundary, so no downstream consumer ever sees a short or long period.
- Sits between the host/control logic and every rate-driven block (animation, input polling, display refresh strobes).

Parameters:
- NUM_CH, 4, number of tick channels (1..16).
- CNT_W, 32, width of each divisor and counter.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- run  in  1  global enable; counters advance only while high
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  scheduler can accept a config request
- cfg_ch  in  CH_W  target channel
- cfg_div  in  CNT_W  new divisor; 0 disables the channel
- tick  out  NUM_CH  one-cycle pulse per channel, registered
- cfg_pending  out  1  an accepted config is waiting for its boundary

Behaviour:
- Reset (rst high at a clk edge):
  - tick=0, all counters=0, all divisors=0 (all channels disabled).
  - FSM=IDLE, cfg_ready=1, cfg_pending=0.
  - Handshakes are ignored while rst is high.
- Channel operation, per channel, with div!=0 and run=1:
  - Compute counter+1 in CNT_W+1 bits.
  - If the result equals div: counter<=0 and tick[i]<=1.
  - Otherwise: counter<=counter+1 and tick[i]<=0.
  - div=1 gives tick high every cycle. div=N gives the first tick N cycles after enable, with period exactly N.
  - div=2^CNT_W-1 must not wrap.
- Disabled or stopped:
  - div=0: counter held at 0, tick[i]=0.
  - run=0: all counters hold their value, all ticks 0. On the cycle run returns high, counting resumes from the held value.
- Config FSM, states IDLE and PENDING:
  - IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch cfg_ch/cfg_div.
    - If cfg_ch>=NUM_CH, drop the request and stay in IDLE.
    - Else, if the target channel is disabled (div=0) or run=0, apply immediately at that edge: div<=cfg_div, counter<=0. Stay in IDLE.
    - Otherwise go to PENDING.
  - PENDING: cfg_ready=0, cfg_pending=1.
    - Apply at the edge where the target channel's terminal condition is true: that tick still fires with the old period, div<=new value, counter<=0. Then return to IDLE.
    - If run drops or rst asserts while PENDING: on run drop, apply at the next edge with counter<=0; on rst, discard the request.
    - Writing div=0 while PENDING: applied at the boundary. The final old-period tick fires, then the channel goes silent.
- Latency:
  - Immediate apply: first new tick arrives cfg_div cycles after the accepting edge.
  - Boundary apply: next tick arrives cfg_div cycles after the boundary tick.
- Simultaneous events:
  - A boundary apply and another channel's tick on the same edge are independent.
  - cfg_ready returns to 1 on the cycle after the apply edge; back-to-back configs are therefore spaced by at least 1 cycle.

Optional Feature:
- Macro TICK_SCHED_SYNC_EN.
- Defined:
  - Adds input port sync_all (1 bit).
  - When sync_all=1 at an edge, all enabled channels' counters are cleared to 0 and no tick fires that cycle.
  - A PENDING config is applied at that edge.
  - sync_all has priority below rst and above run.
- Undefined:
  - No sync_all port; channels are phase-independent.

Decomposition:
- Package tick_sched_pkg holds:
  - the FSM state enum (IDLE, PENDING);
  - default NUM_CH/CNT_W constants;
  - the DIV_DISABLED=0 constant.
- One natural sub-module, tick_channel: counter, divisor register, load strobe, terminal-count output. It is instantiated NUM_CH times via generate.
- tick_scheduler keeps the config FSM, the channel decode and the optional sync.

Test Plan:
- Reset, then configure ch0 div=4 with run=1 -> cfg accepted immediately; tick[0] high at cycles 4,8,12 after accept; other ticks stay 0.
- Ch1 div=1 -> tick[1] high every cycle. Then write div=0 -> after the boundary, tick[1] stays 0 indefinitely.
- Ch0 running div=5, write div=3 mid-period (counter=1) -> cfg_ready=0 and cfg_pending=1 for 3 cycles; tick at the old boundary, then period 3.
- run low for 7 cycles with ch0 div=4 at counter=2 -> no ticks; after run rises, tick fires 2 cycles later.
- cfg_ch=NUM_CH with cfg_valid -> accepted, no divisor changes, FSM stays IDLE. rst asserted while PENDING -> all outputs return to reset values next cycle.
- With TICK_SCHED_SYNC_EN: ch0 div=4, ch1 div=6 out of phase, pulse sync_all -> both tick 4 and 6 cycles later; at cycle 12 both tick together.
